reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Hazard scoreboard and register-file write-port arbiter for the mini RISC-V core. It tracks registers with outstanding long-latency results (loads, MMIO reads) and stalls issue on RAW/WAW hazards or when too many long operations are in flight. It also merges ALU writebacks and LSU completions onto the decoder's single write port (regWrite / rd_i / writeData).

Parameters:
XLEN, 32, data width of register writes.
REG_ADDR_W, 5, register index width (32 registers).
MAX_PENDING, 2, maximum outstanding long-latency operations (1..7).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
issue_valid  in  1  decode stage presents an instruction
issue_rs1  in  REG_ADDR_W  source register 1
issue_rs2  in  REG_ADDR_W  source register 2
issue_rd  in  REG_ADDR_W  destination register
issue_uses_rs1  in  1  instruction reads rs1
issue_uses_rs2  in  1  instruction reads rs2
issue_is_long  in  1  result is returned later via the LSU completion path
issue_stall  out  1  hold decode this cycle (combinational)
alu_wb_valid  in  1  ALU result to write (cannot be stalled)
alu_wb_rd  in  REG_ADDR_W  ALU destination
alu_wb_data  in  XLEN  ALU result
lsu_done_valid  in  1  long-op result available
lsu_done_rd  in  REG_ADDR_W  long-op destination
lsu_done_data  in  XLEN  long-op result
lsu_done_ready  out  1  completion accepted this cycle
rf_we  out  1  to decoder regWrite
rf_waddr  out  REG_ADDR_W  to decoder rd_i
rf_wdata  out  XLEN  to decoder writeData
busy_vec  out  32  per-register pending flag (bit 0 always 0)
pending_cnt  out  3  outstanding long ops
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low at posedge): busy_vec=0, pending_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, err=0. lsu_done_ready is forced 0 and issue_stall is forced 1 while rst is low. Any in-flight operation is discarded with no write.
- issue_stall = issue_valid && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || busy[rd] || (is_long && pending_cnt==MAX_PENDING)). It uses only registered state, with no bypass from same-cycle clears.
- Issue accept = issue_valid && !issue_stall. If is_long: pending_cnt+1 at the edge, and busy[rd] set if rd!=0. Non-long instructions change no state.
- Write-port arbitration (one registered stage, 1-cycle latency):
  - An ALU write is "live" when alu_wb_valid && alu_wb_rd!=0. ALU writes to x0 are dropped and do not occupy the port.
  - lsu_done_ready = rst && !live ALU write. ALU has fixed priority.
  - Edge E: live ALU write loads rf_we=1, waddr, wdata.
  - Edge E, otherwise, if lsu_done_valid: load the LSU result (rf_we = lsu_done_rd!=0) and pending_cnt-1.
  - Otherwise rf_we=0. rf_waddr and rf_wdata hold their last values.
- Busy clear: for an LSU result loaded at edge E, busy[rd] clears at edge E+1, the same edge the register file captures the data. A dependent instruction issues no earlier than the cycle after E+1.
- Simultaneous events:
  - Issue of a long op and LSU acceptance in the same cycle: pending_cnt is unchanged net.
  - A stall decision at pending_cnt==MAX_PENDING holds even if a completion is accepted that cycle.
  - A set and a clear of the same busy bit on one edge cannot occur, because the set requires !busy[rd].
- err is set (sticky until reset) on any of:
  - LSU acceptance with pending_cnt==0;
  - LSU acceptance with lsu_done_rd!=0 and !busy[lsu_done_rd];
  - live ALU write to a busy register.
  On an error, state is still updated, with the pending_cnt decrement saturating at 0.
- LSU completions return in issue order. The block does not check ordering beyond the busy check.

Decomposition:
- Shared package core_pkg: XLEN, REG_ADDR_W, NUM_REGS=32, ZERO_REG=0.
- One sub-module, wb_port_arbiter: holds the ALU/LSU priority logic, the lsu_done_ready generation and the rf_* output register.
- Scoreboard state (busy_vec, pending_cnt, err, stall logic) stays in reg_scoreboard.

Test Plan:
1. Reset, then issue a long op with rd=5 → busy_vec[5]=1, pending_cnt=1. Next cycle, issue with rs1=5, uses_rs1=1 → issue_stall=1. LSU done rd=5, data=0xDEADBEEF at edge E → rf_we=1, waddr=5, wdata=0xDEADBEEF in cycle E+1. busy[5]=0 after E+1, stall drops.
2. With MAX_PENDING=2, issue long ops to x3 and x4 → a third long op (rd=6) has issue_stall=1. A non-long op with rd=7 and no hazards gets issue_stall=0.
3. alu_wb_valid (rd=8, 0x11) and lsu_done_valid (rd=3) in the same cycle → lsu_done_ready=0 and the ALU write appears. Next cycle with no ALU write → LSU accepted, rf_waddr=3.
4. ALU write to x0 with lsu_done_valid → lsu_done_ready=1. A long op with rd=0 increments then decrements pending_cnt with rf_we=0 and busy_vec unchanged.
5. LSU done with pending_cnt=0 → err=1 and stays set. Then reset → err=0 and all outputs return to 0.
6. Reset asserted with pending_cnt=2 and busy[3,4] set → after the edge, busy_vec=0, pending_cnt=0, rf_we=0. lsu_done_ready=0 and issue_stall=1 while rst is low.

Source files
------------

// File: rtl/core_pkg.sv
// Shared widths and constants for the mini RISC-V core's register-file side.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/wb_port_arbiter.sv
// Merges ALU writebacks and LSU completions onto the single register-file write port.
module wb_port_arbiter #(
   parameter int XLEN       = core_pkg::XLEN,
   parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_wb_valid,
   input  logic [REG_ADDR_W-1:0] alu_wb_rd,
   input  logic [XLEN-1:0]       alu_wb_data,
   input  logic                  lsu_done_valid,
   input  logic [REG_ADDR_W-1:0] lsu_done_rd,
   input  logic [XLEN-1:0]       lsu_done_data,
   output logic                  lsu_done_ready,
   output logic                  alu_live,
   output logic                  lsu_accept,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata
);
   import core_pkg::*;

   // ALU writes to x0 are discarded outright, so they never block the LSU.
   assign alu_live       = alu_wb_valid && (alu_wb_rd != ZERO_REG);
   assign lsu_done_ready = rst && !alu_live;
   assign lsu_accept     = lsu_done_valid && lsu_done_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (alu_live) begin
         rf_we    <= 1'b1;
         rf_waddr <= alu_wb_rd;
         rf_wdata <= alu_wb_data;
      end else if (lsu_done_valid) begin
         rf_we    <= (lsu_done_rd != ZERO_REG);
         rf_waddr <= lsu_done_rd;
         rf_wdata <= lsu_done_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end
endmodule

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard: tracks registers awaiting long-latency results and stalls issue on
// RAW/WAW hazards or when too many long operations are outstanding.
module reg_scoreboard #(
   parameter int XLEN        = core_pkg::XLEN,
   parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W,
   parameter int MAX_PENDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rs1,
   input  logic [REG_ADDR_W-1:0] issue_rs2,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_uses_rs1,
   input  logic                  issue_uses_rs2,
   input  logic                  issue_is_long,
   output logic                  issue_stall,
   input  logic                  alu_wb_valid,
   input  logic [REG_ADDR_W-1:0] alu_wb_rd,
   input  logic [XLEN-1:0]       alu_wb_data,
   input  logic                  lsu_done_valid,
   input  logic [REG_ADDR_W-1:0] lsu_done_rd,
   input  logic [XLEN-1:0]       lsu_done_data,
   output logic                  lsu_done_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic [31:0]           busy_vec,
   output logic [2:0]            pending_cnt,
   output logic                  err
);
   import core_pkg::*;

   logic [NUM_REGS-1:0]   busy_q, busy_next;
   logic [2:0]            pending_q, pending_next;
   logic                  err_q, err_next;
   logic                  clr_valid_q;
   logic [REG_ADDR_W-1:0] clr_rd_q;
   logic                  hazard, long_accept;
   logic                  alu_live, lsu_accept;

   wb_port_arbiter #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_arb (
      .clk            (clk),
      .rst            (rst),
      .alu_wb_valid   (alu_wb_valid),
      .alu_wb_rd      (alu_wb_rd),
      .alu_wb_data    (alu_wb_data),
      .lsu_done_valid (lsu_done_valid),
      .lsu_done_rd    (lsu_done_rd),
      .lsu_done_data  (lsu_done_data),
      .lsu_done_ready (lsu_done_ready),
      .alu_live       (alu_live),
      .lsu_accept     (lsu_accept),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata)
   );

   // Stall looks only at registered state; a clear landing this cycle is not bypassed.
   always_comb begin
      hazard = 1'b0;
      if (issue_uses_rs1 && busy_q[issue_rs1])
         hazard = 1'b1;
      if (issue_uses_rs2 && busy_q[issue_rs2])
         hazard = 1'b1;
      if (busy_q[issue_rd])
         hazard = 1'b1;
      if (issue_is_long && (pending_q == 3'(MAX_PENDING)))
         hazard = 1'b1;
      issue_stall = !rst || (issue_valid && hazard);
      long_accept = rst && issue_valid && !hazard && issue_is_long;
   end

   // The busy clear is delayed one edge so it coincides with the register-file write.
   always_comb begin
      busy_next = busy_q;
      if (clr_valid_q)
         busy_next[clr_rd_q] = 1'b0;
      if (long_accept && (issue_rd != ZERO_REG))
         busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;

      pending_next = pending_q;
      if (lsu_accept && (pending_q != 3'd0))
         pending_next = pending_q - 3'd1;
      if (long_accept)
         pending_next = pending_next + 3'd1;

      err_next = err_q
               || (lsu_accept && (pending_q == 3'd0))
               || (lsu_accept && (lsu_done_rd != ZERO_REG) && !busy_q[lsu_done_rd])
               || (alu_live && busy_q[alu_wb_rd]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q      <= '0;
         pending_q   <= '0;
         err_q       <= 1'b0;
         clr_valid_q <= 1'b0;
         clr_rd_q    <= '0;
      end else begin
         busy_q      <= busy_next;
         pending_q   <= pending_next;
         err_q       <= err_next;
         clr_valid_q <= lsu_accept && (lsu_done_rd != ZERO_REG);
         clr_rd_q    <= lsu_done_rd;
      end
   end

   assign busy_vec    = busy_q;
   assign pending_cnt = pending_q;
   assign err         = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench: expected register-file writes are queued at stimulus time and checked
// by an independent monitor; scoreboard state is compared against hand-computed values.
module tb_reg_scoreboard;
   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_uses_rs1, issue_uses_rs2, issue_is_long;
   logic        issue_stall;
   logic        alu_wb_valid;
   logic [4:0]  alu_wb_rd;
   logic [31:0] alu_wb_data;
   logic        lsu_done_valid;
   logic [4:0]  lsu_done_rd;
   logic [31:0] lsu_done_data;
   logic        lsu_done_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_vec;
   logic [2:0]  pending_cnt;
   logic        err;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   reg_scoreboard dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
      .issue_is_long(issue_is_long), .issue_stall(issue_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .lsu_done_valid(lsu_done_valid), .lsu_done_rd(lsu_done_rd),
      .lsu_done_data(lsu_done_data), .lsu_done_ready(lsu_done_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_vec(busy_vec), .pending_cnt(pending_cnt), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every write the port presents must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL wb_unexpected got rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
               errors++;
               $display("[TB] FAIL wb_data got rd=%0d data=%h, required rd=%0d data=%h",
                        rf_waddr, rf_wdata, e.rd, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1, input logic u2, input logic lng);
      issue_valid    = v;
      issue_rs1      = rs1;
      issue_rs2      = rs2;
      issue_rd       = rd;
      issue_uses_rs1 = u1;
      issue_uses_rs2 = u2;
      issue_is_long  = lng;
   endtask

   task automatic setAlu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_wb_valid = v;
      alu_wb_rd    = rd;
      alu_wb_data  = d;
   endtask

   task automatic setLsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lsu_done_valid = v;
      lsu_done_rd    = rd;
      lsu_done_data  = d;
   endtask

   task automatic expectWrite(input logic [4:0] rd, input logic [31:0] d);
      wb_t e;
      e.rd   = rd;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      setAlu(0, 0, 0);
      setLsu(1, 5'd3, 32'h1);
      #1;
      checkOutput("rst_stall", 32'(issue_stall), 32'd1);
      checkOutput("rst_ready", 32'(lsu_done_ready), 32'd0);
      step();
      step();
      setLsu(0, 0, 0);
      checkOutput("rst_busy", busy_vec, 32'h0);
      checkOutput("rst_pending", 32'(pending_cnt), 32'd0);
      checkOutput("rst_we", 32'(rf_we), 32'd0);
      checkOutput("rst_waddr", 32'(rf_waddr), 32'd0);
      checkOutput("rst_wdata", rf_wdata, 32'h0);
      checkOutput("rst_err", 32'(err), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("idle_stall", 32'(issue_stall), 32'd0);

      // Long op to x5, dependent stalls until the clear lands one edge after the write.
      applyStimulus(1, 0, 0, 5'd5, 0, 0, 1);
      #1;
      checkOutput("t1_issue_stall", 32'(issue_stall), 32'd0);
      step();
      checkOutput("t1_busy", busy_vec, 32'h20);
      checkOutput("t1_pending", 32'(pending_cnt), 32'd1);
      applyStimulus(1, 5'd5, 0, 5'd9, 1, 0, 0);
      setLsu(1, 5'd5, 32'hDEADBEEF);
      expectWrite(5'd5, 32'hDEADBEEF);
      #1;
      checkOutput("t1_raw_stall", 32'(issue_stall), 32'd1);
      checkOutput("t1_ready", 32'(lsu_done_ready), 32'd1);
      step();
      setLsu(0, 0, 0);
      checkOutput("t1_we", 32'(rf_we), 32'd1);
      checkOutput("t1_waddr", 32'(rf_waddr), 32'd5);
      checkOutput("t1_wdata", rf_wdata, 32'hDEADBEEF);
      checkOutput("t1_pending_dec", 32'(pending_cnt), 32'd0);
      checkOutput("t1_busy_held", busy_vec, 32'h20);
      checkOutput("t1_stall_held", 32'(issue_stall), 32'd1);
      step();
      checkOutput("t1_busy_clr", busy_vec, 32'h0);
      checkOutput("t1_stall_drop", 32'(issue_stall), 32'd0);
      checkOutput("t1_we_off", 32'(rf_we), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Fill the long-op budget, then probe a third long op and an unrelated short op.
      applyStimulus(1, 0, 0, 5'd3, 0, 0, 1);
      step();
      applyStimulus(1, 0, 0, 5'd4, 0, 0, 1);
      step();
      checkOutput("t2_pending", 32'(pending_cnt), 32'd2);
      checkOutput("t2_busy", busy_vec, 32'h18);
      applyStimulus(1, 0, 0, 5'd6, 0, 0, 1);
      #1;
      checkOutput("t2_full_stall", 32'(issue_stall), 32'd1);
      applyStimulus(1, 5'd1, 5'd2, 5'd7, 1, 1, 0);
      #1;
      checkOutput("t2_short_go", 32'(issue_stall), 32'd0);
      applyStimulus(1, 5'd3, 5'd2, 5'd7, 0, 1, 0);
      #1;
      checkOutput("t2_unused_rs1", 32'(issue_stall), 32'd0);
      applyStimulus(1, 5'd1, 5'd4, 5'd7, 0, 1, 0);
      #1;
      checkOutput("t2_rs2_stall", 32'(issue_stall), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // ALU wins the port; LSU waits and is taken the following cycle.
      setAlu(1, 5'd8, 32'h11);
      setLsu(1, 5'd3, 32'h33);
      expectWrite(5'd8, 32'h11);
      #1;
      checkOutput("t3_ready_low", 32'(lsu_done_ready), 32'd0);
      step();
      checkOutput("t3_alu_waddr", 32'(rf_waddr), 32'd8);
      checkOutput("t3_pending_hold", 32'(pending_cnt), 32'd2);
      setAlu(0, 0, 0);
      expectWrite(5'd3, 32'h33);
      #1;
      checkOutput("t3_ready_high", 32'(lsu_done_ready), 32'd1);
      step();
      setLsu(0, 0, 0);
      checkOutput("t3_lsu_waddr", 32'(rf_waddr), 32'd3);
      checkOutput("t3_pending", 32'(pending_cnt), 32'd1);
      step();
      checkOutput("t3_busy", busy_vec, 32'h10);

      // ALU write to x0 never occupies the port.
      setAlu(1, 5'd0, 32'h55);
      setLsu(1, 5'd4, 32'h44);
      expectWrite(5'd4, 32'h44);
      #1;
      checkOutput("t4_ready_x0", 32'(lsu_done_ready), 32'd1);
      step();
      setAlu(0, 0, 0);
      setLsu(0, 0, 0);
      checkOutput("t4_pending", 32'(pending_cnt), 32'd0);
      step();
      checkOutput("t4_busy", busy_vec, 32'h0);
      applyStimulus(1, 0, 0, 5'd0, 0, 0, 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_x0_pending", 32'(pending_cnt), 32'd1);
      checkOutput("t4_x0_busy", busy_vec, 32'h0);
      setLsu(1, 5'd0, 32'h99);
      step();
      setLsu(0, 0, 0);
      checkOutput("t4_x0_we", 32'(rf_we), 32'd0);
      checkOutput("t4_x0_pending_dec", 32'(pending_cnt), 32'd0);
      checkOutput("t4_x0_err", 32'(err), 32'd0);

      // Completion with nothing outstanding is a protocol error and is sticky.
      setLsu(1, 5'd2, 32'h0BAD);
      expectWrite(5'd2, 32'h0BAD);
      step();
      setLsu(0, 0, 0);
      checkOutput("t5_err", 32'(err), 32'd1);
      checkOutput("t5_pending_sat", 32'(pending_cnt), 32'd0);
      step();
      checkOutput("t5_err_sticky", 32'(err), 32'd1);

      // Reset with work in flight discards everything.
      applyStimulus(1, 0, 0, 5'd3, 0, 0, 1);
      step();
      applyStimulus(1, 0, 0, 5'd4, 0, 0, 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t6_pending_pre", 32'(pending_cnt), 32'd2);
      checkOutput("t6_busy_pre", busy_vec, 32'h18);
      rst = 1'b0;
      setLsu(1, 5'd3, 32'h77);
      #1;
      checkOutput("t6_ready_rst", 32'(lsu_done_ready), 32'd0);
      checkOutput("t6_stall_rst", 32'(issue_stall), 32'd1);
      step();
      checkOutput("t6_busy", busy_vec, 32'h0);
      checkOutput("t6_pending", 32'(pending_cnt), 32'd0);
      checkOutput("t6_we", 32'(rf_we), 32'd0);
      checkOutput("t6_err", 32'(err), 32'd0);
      setLsu(0, 0, 0);
      rst = 1'b1;

      // ALU writing a register still owned by a long op flags an error.
      applyStimulus(1, 0, 0, 5'd10, 0, 0, 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      setAlu(1, 5'd10, 32'h77);
      expectWrite(5'd10, 32'h77);
      step();
      setAlu(0, 0, 0);
      checkOutput("t7_alu_busy_err", 32'(err), 32'd1);
      setLsu(1, 5'd10, 32'hA0);
      expectWrite(5'd10, 32'hA0);
      step();
      setLsu(0, 0, 0);
      step();
      checkOutput("t7_busy", busy_vec, 32'h0);
      checkOutput("t7_pending", 32'(pending_cnt), 32'd0);
      step();
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
